angle_job_scheduler: RTL

- Front-end sequencer for the inverse-kinematics angle calculator.
- Accepts (x, y) target requests into a small FIFO and launches one calculation at a time.
- Detects completion, captures th1/th2, and presents each result on a valid/ready output to the joint motor controllers.
- Watchdog times out hung calculations, resets the calculator and reports an error result.

---
 rtl/angle_job_scheduler_if.sv | 24 ++
 rtl/angle_job_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/angle_job_scheduler_if.sv
// Target-request and result handshake bundle for angle_job_scheduler.
// slave = scheduler side, master = target producer / joint-controller consumer side.
interface angle_job_scheduler_if;
    logic               tgt_valid;
    logic               tgt_ready;
    logic [13:0]        tgt_x;
    logic [13:0]        tgt_y;
    logic               res_valid;
    logic               res_ready;
    logic signed [12:0] res_th1;
    logic signed [12:0] res_th2;
    logic               res_err;
    logic               res_limit;

    modport slave (
        input  tgt_valid, tgt_x, tgt_y, res_ready,
        output tgt_ready, res_valid, res_th1, res_th2, res_err, res_limit
    );

    modport master (
        output tgt_valid, tgt_x, tgt_y, res_ready,
        input  tgt_ready, res_valid, res_th1, res_th2, res_err, res_limit
    );
endinterface

// File: rtl/angle_job_scheduler.sv
// Queues (x, y) targets, runs the IK angle calculator one job at a time, and presents th1/th2 results.
// Optional joint-limit clamping is enabled by defining ANGLE_SCHED_JOINT_LIMIT_EN.
module angle_job_scheduler #(
    parameter int DEPTH           = 4,
    parameter int LAUNCH_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int CALC_RST_CYCLES = 2,
    parameter int TH1_MIN         = -2048,
    parameter int TH1_MAX         = 2047,
    parameter int TH2_MIN         = -2048,
    parameter int TH2_MAX         = 2047
) (
    input  logic                     clk,
    input  logic                     reset,
    angle_job_scheduler_if.slave     bus,
    output logic [13:0]              calc_x,
    output logic [13:0]              calc_y,
    output logic                     calc_enable,
    output logic                     calc_reset,
    input  logic                     calc_ready,
    input  logic signed [12:0]       calc_th1,
    input  logic signed [12:0]       calc_th2,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + LAUNCH_CYCLES + CALC_RST_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, ABORT, PRESENT} state_t;

    state_t             state, state_nxt;
    logic [13:0]        mem_x [DEPTH];
    logic [13:0]        mem_y [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [CW-1:0]      cnt;
    logic               ready_prev;
    logic               full, empty, push, pop, done_edge;
    logic signed [12:0] cap_th1, cap_th2;
    logic               cap_limit;

    assign full          = (count == (AW+1)'(DEPTH));
    assign empty         = (count == '0);
    assign push          = bus.tgt_valid && !full;
    assign pop           = (state == IDLE) && !empty && !bus.res_valid;
    assign done_edge     = (state == BUSY) && calc_ready && !ready_prev;

    assign bus.tgt_ready = !full;
    assign bus.res_valid = (state == PRESENT);
    assign calc_enable   = (state == LAUNCH);
    assign calc_reset    = (state == ABORT);
    assign busy          = (state != IDLE) || !empty;
    assign fifo_count    = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= bus.tgt_x;
            mem_y[wr_ptr] <= bus.tgt_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            calc_x <= '0;
            calc_y <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                calc_x <= mem_x[rd_ptr];
                calc_y <= mem_y[rd_ptr];
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Completion edge is tested before the timeout so it wins when both land together.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pop) state_nxt = LAUNCH;
            LAUNCH:  if (cnt == CW'(LAUNCH_CYCLES - 1)) state_nxt = BUSY;
            BUSY: begin
                if (done_edge)                            state_nxt = PRESENT;
                else if (cnt == CW'(TIMEOUT_CYCLES - 1))  state_nxt = ABORT;
            end
            ABORT:   if (cnt == CW'(CALC_RST_CYCLES - 1)) state_nxt = PRESENT;
            PRESENT: if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ready_prev is cleared on the pop and then tracks calc_ready through LAUNCH as well,
    // so a level left high by the previous job is already seen as "old" when BUSY starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            ready_prev <= 1'b0;
        end else begin
            if (state_nxt != state)                        cnt <= '0;
            else if (state inside {LAUNCH, BUSY, ABORT})   cnt <= cnt + 1'b1;
            ready_prev <= pop ? 1'b0 : calc_ready;
        end
    end

`ifdef ANGLE_SCHED_JOINT_LIMIT_EN
    localparam logic signed [12:0] TH1_LO = 13'(TH1_MIN);
    localparam logic signed [12:0] TH1_HI = 13'(TH1_MAX);
    localparam logic signed [12:0] TH2_LO = 13'(TH2_MIN);
    localparam logic signed [12:0] TH2_HI = 13'(TH2_MAX);

    always_comb begin
        cap_th1   = calc_th1;
        cap_th2   = calc_th2;
        cap_limit = 1'b0;
        if (calc_th1 < TH1_LO) begin
            cap_th1   = TH1_LO;
            cap_limit = 1'b1;
        end else if (calc_th1 > TH1_HI) begin
            cap_th1   = TH1_HI;
            cap_limit = 1'b1;
        end
        if (calc_th2 < TH2_LO) begin
            cap_th2   = TH2_LO;
            cap_limit = 1'b1;
        end else if (calc_th2 > TH2_HI) begin
            cap_th2   = TH2_HI;
            cap_limit = 1'b1;
        end
    end
`else
    assign cap_th1   = calc_th1;
    assign cap_th2   = calc_th2;
    assign cap_limit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.res_th1   <= '0;
            bus.res_th2   <= '0;
            bus.res_err   <= 1'b0;
            bus.res_limit <= 1'b0;
        end else if (done_edge) begin
            bus.res_th1   <= cap_th1;
            bus.res_th2   <= cap_th2;
            bus.res_err   <= 1'b0;
            bus.res_limit <= cap_limit;
        end else if (state == ABORT && state_nxt == PRESENT) begin
            bus.res_th1   <= '0;
            bus.res_th2   <= '0;
            bus.res_err   <= 1'b1;
            bus.res_limit <= 1'b0;
        end
    end
endmodule
